// File: rtl/ram_prog_bh.sv
// ram_prog_bh: loads sixteen host nibbles into an external 16x4 RAM with a
// setup/pulse/hold write cycle per word. It then reads the RAM back and
// compares the XOR checksum of the readback with the checksum of the written data.
module ram_prog_bh (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic       START,
    input  logic       WR_VALID,
    input  logic [3:0] WR_DATA,
    output logic       WR_READY,
    input  logic [3:0] S,
    output logic       CE_N,
    output logic       WE_N,
    output logic [3:0] A,
    output logic [3:0] D,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_WAIT  = 3'd1,
        W_SETUP = 3'd2,
        W_PULSE = 3'd3,
        W_HOLD  = 3'd4,
        R_READ  = 3'd5,
        FIN     = 3'd6
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] addr_q, addr_d;
    logic [3:0] data_q, data_d;
    logic [3:0] wsum_q, wsum_d;
    logic [3:0] rsum_q, rsum_d;
    logic       pass_q, pass_d;

    // Next-state and datapath update for the load-and-verify sequence
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wsum_d  = wsum_q;
        rsum_d  = rsum_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = W_WAIT;
                    addr_d  = '0;
                    wsum_d  = '0;
                    rsum_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            W_WAIT: begin
                if (WR_VALID) begin
                    data_d  = WR_DATA;
                    wsum_d  = wsum_q ^ WR_DATA;
                    state_d = W_SETUP;
                end
            end
            W_SETUP: state_d = W_PULSE;
            W_PULSE: state_d = W_HOLD;
            W_HOLD: begin
                if (addr_q == 4'hF) begin
                    addr_d  = '0;
                    state_d = R_READ;
                end else begin
                    addr_d  = addr_q + 4'd1;
                    state_d = W_WAIT;
                end
            end
            R_READ: begin
                // RAM data is active-low; undo that before accumulating
                rsum_d = rsum_q ^ ~S;
                if (addr_q == 4'hF) begin
                    state_d = FIN;
                    // Resolve the verdict one edge early so PASS is already
                    // valid in the DONE cycle; FIN recomputes the same value.
                    pass_d  = (rsum_d == wsum_q);
                end else begin
                    addr_d  = addr_q + 4'd1;
                end
            end
            FIN: begin
                pass_d  = (rsum_q == wsum_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by CLR_N
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            wsum_q  <= '0;
            rsum_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wsum_q  <= wsum_d;
            rsum_q  <= rsum_d;
            pass_q  <= pass_d;
        end
    end

    // RAM strobes and status flags decoded purely from the state register
    always_comb begin
        CE_N     = 1'b1;
        WE_N     = 1'b1;
        WR_READY = 1'b0;
        DONE     = 1'b0;
        BUSY     = (state_q != IDLE);
        case (state_q)
            W_WAIT:  WR_READY = 1'b1;
            W_PULSE: begin
                CE_N = 1'b0;
                WE_N = 1'b0;
            end
            R_READ:  CE_N = 1'b0;
            FIN:     DONE = 1'b1;
            default: ;
        endcase
    end

    assign A    = addr_q;
    assign D    = data_q;
    assign PASS = pass_q;

endmodule
